// File: rtl/reg_file_pkg.sv
// Shared types and sizing for the architectural register file.
// Latency: n/a (definitions only).
// Backpressure: n/a; the global rdy input freezes register file state.
package reg_file_pkg;

  localparam int REG_NUM       = 32;
  localparam int ROB_POS_WIDTH = 4;
  localparam int DATA_WIDTH    = 32;

  typedef logic [4:0]               REG_POS_TYPE;
  typedef logic [DATA_WIDTH-1:0]    DATA_TYPE;
  // A wrapped ROB position doubles as a rename tag: MSB set means "pending".
  typedef logic [ROB_POS_WIDTH:0]   ROB_WRAP_POS_TYPE;
  typedef logic [ROB_POS_WIDTH-1:0] ROB_POS_TYPE;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // All-zero tag: the register holds its committed value, no producer in flight.
  localparam ROB_WRAP_POS_TYPE NO_TAG = '0;

endpackage

// File: rtl/reg_file_read_port.sv
// One decoder source-operand read: x0 forcing, commit bypass, array lookup.
// Latency: purely combinational.
// Backpressure: none; always produces a value/tag pair for the current index.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic [4:0]                               rs,
  input  logic [REG_NUM-1:0][DATA_WIDTH-1:0]       val_arr,
  input  logic [REG_NUM-1:0][ROB_POS_WIDTH:0]      tag_arr,
  input  logic                                     cm_en,
  input  logic [4:0]                               cm_rd,
  input  logic [DATA_WIDTH-1:0]                    cm_val,
  input  logic [ROB_POS_WIDTH:0]                   cm_pos,
  output logic [DATA_WIDTH-1:0]                    val,
  output logic [ROB_POS_WIDTH:0]                   tag
);

  ROB_WRAP_POS_TYPE cur_tag;
  logic             bypass;

  assign cur_tag = tag_arr[rs];
  // Bypass only when the committing entry is still the register's current
  // producer; a stale commit must not hide a newer rename.
  assign bypass  = cm_en && (cm_rd == rs) && (cur_tag == cm_pos);

  // Select x0 zero, committing value, or the stored value/tag.
  always_comb begin
    val = '0;
    tag = NO_TAG;
    if (rs == 5'd0) begin
      val = '0;
      tag = NO_TAG;
    end else if (bypass) begin
      val = cm_val;
      tag = NO_TAG;
    end else begin
      val = val_arr[rs];
      tag = cur_tag;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file holding committed values and rename tags per register.
// Latency: commit/rename visible to reads the cycle after the edge; commit data bypassed same cycle.
// Backpressure: rdy low freezes all state; reads stay combinational and valid.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clr,
  input  logic                     issue_to_reg_enable,
  input  logic [4:0]               issue_to_reg_rd,
  input  logic [ROB_POS_WIDTH:0]   issue_to_reg_rob_pos,
  input  logic                     rob_to_reg_enable,
  input  logic [4:0]               rob_to_reg_rd,
  input  logic [DATA_WIDTH-1:0]    rob_to_reg_val,
  input  logic [ROB_POS_WIDTH:0]   commit_rob_pos,
  input  logic [4:0]               dc_to_reg_rs1_pos,
  input  logic [4:0]               dc_to_reg_rs2_pos,
  output logic [DATA_WIDTH-1:0]    reg_to_dc_rs1_val,
  output logic [ROB_POS_WIDTH:0]   reg_to_dc_rs1_rob_pos,
  output logic [DATA_WIDTH-1:0]    reg_to_dc_rs2_val,
  output logic [ROB_POS_WIDTH:0]   reg_to_dc_rs2_rob_pos
);

  logic [REG_NUM-1:0][DATA_WIDTH-1:0]    val_q;
  logic [REG_NUM-1:0][ROB_POS_WIDTH:0]   tag_q;

  logic commit_wr;
  logic commit_clr;
  logic issue_wr;

  // x0 is never written or tagged, so its array entry stays at reset value.
  assign commit_wr  = rob_to_reg_enable && (rob_to_reg_rd != 5'd0);
  assign commit_clr = commit_wr && (tag_q[rob_to_reg_rd] == commit_rob_pos);
  assign issue_wr   = issue_to_reg_enable && (issue_to_reg_rd != 5'd0);

  // Commit writes value; flush wipes all tags; a same-cycle rename overrides the tag clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      tag_q <= '0;
    end else if (rdy) begin
      if (commit_wr) begin
        val_q[rob_to_reg_rd] <= rob_to_reg_val;
      end
      if (clr) begin
        tag_q <= '0;
      end else begin
        if (commit_clr) begin
          tag_q[rob_to_reg_rd] <= NO_TAG;
        end
        if (issue_wr) begin
          tag_q[issue_to_reg_rd] <= issue_to_reg_rob_pos;
        end
      end
    end
  end

  reg_file_read_port u_rs1 (
    .rs      (dc_to_reg_rs1_pos),
    .val_arr (val_q),
    .tag_arr (tag_q),
    .cm_en   (rob_to_reg_enable),
    .cm_rd   (rob_to_reg_rd),
    .cm_val  (rob_to_reg_val),
    .cm_pos  (commit_rob_pos),
    .val     (reg_to_dc_rs1_val),
    .tag     (reg_to_dc_rs1_rob_pos)
  );

  reg_file_read_port u_rs2 (
    .rs      (dc_to_reg_rs2_pos),
    .val_arr (val_q),
    .tag_arr (tag_q),
    .cm_en   (rob_to_reg_enable),
    .cm_rd   (rob_to_reg_rd),
    .cm_val  (rob_to_reg_val),
    .cm_pos  (commit_rob_pos),
    .val     (reg_to_dc_rs2_val),
    .tag     (reg_to_dc_rs2_rob_pos)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus randomized traffic against a reference model.
// Latency: reads checked mid-cycle; model advanced at each rising edge.
// Backpressure: rdy toggled randomly to exercise state freeze.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        issue_to_reg_enable;
  logic [4:0]  issue_to_reg_rd;
  logic [4:0]  issue_to_reg_rob_pos;
  logic        rob_to_reg_enable;
  logic [4:0]  rob_to_reg_rd;
  logic [31:0] rob_to_reg_val;
  logic [4:0]  commit_rob_pos;
  logic [4:0]  dc_to_reg_rs1_pos;
  logic [4:0]  dc_to_reg_rs2_pos;
  logic [31:0] reg_to_dc_rs1_val;
  logic [4:0]  reg_to_dc_rs1_rob_pos;
  logic [31:0] reg_to_dc_rs2_val;
  logic [4:0]  reg_to_dc_rs2_rob_pos;

  int total = 0;
  int bad   = 0;

  // Reference state: committed value and pending producer per register.
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];

  reg_file dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .clr                   (clr),
    .issue_to_reg_enable   (issue_to_reg_enable),
    .issue_to_reg_rd       (issue_to_reg_rd),
    .issue_to_reg_rob_pos  (issue_to_reg_rob_pos),
    .rob_to_reg_enable     (rob_to_reg_enable),
    .rob_to_reg_rd         (rob_to_reg_rd),
    .rob_to_reg_val        (rob_to_reg_val),
    .commit_rob_pos        (commit_rob_pos),
    .dc_to_reg_rs1_pos     (dc_to_reg_rs1_pos),
    .dc_to_reg_rs2_pos     (dc_to_reg_rs2_pos),
    .reg_to_dc_rs1_val     (reg_to_dc_rs1_val),
    .reg_to_dc_rs1_rob_pos (reg_to_dc_rs1_rob_pos),
    .reg_to_dc_rs2_val     (reg_to_dc_rs2_val),
    .reg_to_dc_rs2_rob_pos (reg_to_dc_rs2_rob_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endtask

  // A register whose current producer is the committing entry is ready now.
  function automatic logic fwd(input logic [4:0] rs);
    return rs != 0 && rob_to_reg_enable && rob_to_reg_rd == rs && m_tag[rs] == commit_rob_pos;
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (fwd(rs)) return rob_to_reg_val;
    return m_val[rs];
  endfunction

  function automatic logic [4:0] exp_tag(input logic [4:0] rs);
    if (rs == 0 || fwd(rs)) return 5'd0;
    return m_tag[rs];
  endfunction

  task automatic check_reads();
    chk("rs1_val", reg_to_dc_rs1_val,            exp_val(dc_to_reg_rs1_pos));
    chk("rs1_tag", {27'd0, reg_to_dc_rs1_rob_pos}, {27'd0, exp_tag(dc_to_reg_rs1_pos)});
    chk("rs2_val", reg_to_dc_rs2_val,            exp_val(dc_to_reg_rs2_pos));
    chk("rs2_tag", {27'd0, reg_to_dc_rs2_rob_pos}, {27'd0, exp_tag(dc_to_reg_rs2_pos)});
  endtask

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_edge();
    logic match;
    if (!rdy) return;
    match = rob_to_reg_enable && rob_to_reg_rd != 0 && m_tag[rob_to_reg_rd] == commit_rob_pos;
    if (rob_to_reg_enable && rob_to_reg_rd != 0) m_val[rob_to_reg_rd] = rob_to_reg_val;
    if (clr) begin
      for (int i = 0; i < 32; i++) m_tag[i] = '0;
    end else begin
      if (match) m_tag[rob_to_reg_rd] = '0;
      if (issue_to_reg_enable && issue_to_reg_rd != 0) m_tag[issue_to_reg_rd] = issue_to_reg_rob_pos;
    end
  endtask

  task automatic idle();
    rdy = 1'b1;
    clr = 1'b0;
    issue_to_reg_enable  = 1'b0;
    issue_to_reg_rd      = '0;
    issue_to_reg_rob_pos = '0;
    rob_to_reg_enable    = 1'b0;
    rob_to_reg_rd        = '0;
    rob_to_reg_val       = '0;
    commit_rob_pos       = '0;
  endtask

  // Check reads mid-cycle, then take the edge in both model and DUT.
  task automatic cyc();
    @(negedge clk);
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] pos);
    issue_to_reg_enable = 1'b1;
    issue_to_reg_rd = rd;
    issue_to_reg_rob_pos = pos;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] pos, input logic [31:0] v);
    rob_to_reg_enable = 1'b1;
    rob_to_reg_rd = rd;
    commit_rob_pos = pos;
    rob_to_reg_val = v;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    dc_to_reg_rs1_pos = 5'd5;
    dc_to_reg_rs2_pos = 5'd0;
    #2;
    chk("rst_rs1_val", reg_to_dc_rs1_val, 32'h0);
    chk("rst_rs1_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);
    chk("rst_rs2_val", reg_to_dc_rs2_val, 32'h0);
    chk("rst_rs2_tag", {27'd0, reg_to_dc_rs2_rob_pos}, 32'h0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Rename then matching commit, with bypass on the commit cycle.
    issue(5, 5'h11); cyc(); idle();
    #1 chk("ren5_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h11);
    cyc();
    commit(5, 5'h11, 32'hDEADBEEF);
    #1 chk("byp5_val", reg_to_dc_rs1_val, 32'hDEADBEEF);
    chk("byp5_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);
    cyc(); idle();
    #1 chk("arr5_val", reg_to_dc_rs1_val, 32'hDEADBEEF);
    chk("arr5_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);

    // Stale commit keeps the newer rename.
    dc_to_reg_rs1_pos = 5'd7;
    issue(7, 5'h12); cyc();
    issue(7, 5'h13); cyc(); idle();
    commit(7, 5'h12, 32'h55);
    #1 chk("stale7_byp_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h13);
    cyc(); idle();
    #1 chk("stale7_val", reg_to_dc_rs1_val, 32'h55);
    chk("stale7_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h13);
    commit(7, 5'h13, 32'h66); cyc(); idle();
    #1 chk("fin7_val", reg_to_dc_rs1_val, 32'h66);
    chk("fin7_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);

    // Same-cycle rename and commit on one register: rename tag wins.
    dc_to_reg_rs2_pos = 5'd9;
    issue(9, 5'h10); cyc(); idle();
    issue(9, 5'h14); commit(9, 5'h10, 32'hAA);
    #1 chk("same9_val", reg_to_dc_rs2_val, 32'hAA);
    chk("same9_tag", {27'd0, reg_to_dc_rs2_rob_pos}, 32'h0);
    cyc(); idle();
    #1 chk("next9_val", reg_to_dc_rs2_val, 32'hAA);
    chk("next9_tag", {27'd0, reg_to_dc_rs2_rob_pos}, 32'h14);

    // Flush together with a commit and a discarded rename.
    issue(1, 5'h15); cyc();
    issue(2, 5'h16); cyc();
    issue(31, 5'h17); cyc(); idle();
    clr = 1'b1; commit(4, 5'h18, 32'h1234); issue(6, 5'h19);
    cyc(); idle();
    dc_to_reg_rs1_pos = 5'd1; dc_to_reg_rs2_pos = 5'd31;
    #1 chk("clr1_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);
    chk("clr31_tag", {27'd0, reg_to_dc_rs2_rob_pos}, 32'h0);
    dc_to_reg_rs1_pos = 5'd4; dc_to_reg_rs2_pos = 5'd6;
    #1 chk("clr4_val", reg_to_dc_rs1_val, 32'h1234);
    chk("clr6_tag", {27'd0, reg_to_dc_rs2_rob_pos}, 32'h0);
    dc_to_reg_rs1_pos = 5'd2;
    #1 chk("clr2_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);

    // x0 ignores writes and renames.
    dc_to_reg_rs1_pos = 5'd0;
    commit(0, 5'h00, 32'hFFFFFFFF); issue(0, 5'h1A);
    cyc(); idle();
    #1 chk("x0_val", reg_to_dc_rs1_val, 32'h0);
    chk("x0_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);

    // rdy low freezes state.
    dc_to_reg_rs1_pos = 5'd8;
    rdy = 1'b0; commit(8, 5'h00, 32'h77); issue(8, 5'h1B);
    cyc(); idle();
    #1 chk("frz8_val", reg_to_dc_rs1_val, 32'h0);
    chk("frz8_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);

    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1)
        issue(5'($urandom_range(0, 7)), {1'b1, 4'($urandom_range(0, 15))});
      if ($urandom_range(0, 1) == 1) begin
        rd = 5'($urandom_range(0, 7));
        commit(rd, ($urandom_range(0, 1) == 1) ? m_tag[rd] : {1'b1, 4'($urandom_range(0, 15))},
               $urandom);
      end
      dc_to_reg_rs1_pos = 5'($urandom_range(0, 8));
      dc_to_reg_rs2_pos = 5'($urandom_range(0, 8));
      cyc();
    end

    // Asynchronous reset mid-cycle clears tags without an edge.
    idle();
    dc_to_reg_rs1_pos = 5'd3;
    issue(3, 5'h1B); cyc(); idle();
    #1 chk("pre_rst3_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h1B);
    @(posedge clk); model_edge();
    #3 rst = 1'b1;
    #1 chk("arst3_tag", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags.
- Sits directly downstream of the reorder buffer and consumes its commit outputs: register write, committed ROB position, and flush.
- Also receives the rename (rd to ROB tag) from issue each cycle.
- Gives the decoder, per source operand, either a committed value or the ROB tag that will produce it.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- ROB_POS_WIDTH, 4, ROB index bits; a tag is ROB_POS_WIDTH+1 bits, MSB=1 valid, all-zero means "no dependency".
- DATA_WIDTH, 32, register width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- clr  in  1  ROB flush (misprediction).
- issue_to_reg_enable  in  1  rename valid this cycle.
- issue_to_reg_rd  in  5  destination register being renamed.
- issue_to_reg_rob_pos  in  ROB_POS_WIDTH+1  tag assigned to rd, MSB=1.
- rob_to_reg_enable  in  1  commit write valid.
- rob_to_reg_rd  in  5  commit destination.
- rob_to_reg_val  in  DATA_WIDTH  commit value.
- commit_rob_pos  in  ROB_POS_WIDTH+1  tag of the committing entry.
- dc_to_reg_rs1_pos  in  5  source 1 index.
- dc_to_reg_rs2_pos  in  5  source 2 index.
- reg_to_dc_rs1_val  out  DATA_WIDTH  source 1 value; meaningful only when the rs1 tag is 0.
- reg_to_dc_rs1_rob_pos  out  ROB_POS_WIDTH+1  rs1 pending tag; 0 means ready.
- reg_to_dc_rs2_val  out  DATA_WIDTH  source 2 value.
- reg_to_dc_rs2_rob_pos  out  ROB_POS_WIDTH+1  rs2 pending tag.

Behaviour:
- State: val[0..31] and tag[0..31].
- Reset (asynchronous): every val = 0 and every tag = 0, immediately.
  - Outputs are combinational, so they read 0/0 throughout reset.
- rdy low: no state update. Reads stay combinational and valid.
- Commit (posedge, rdy=1, rob_to_reg_enable=1, rob_to_reg_rd != 0):
  - val[rd] <= rob_to_reg_val, unconditionally.
  - tag[rd] <= 0 only if tag[rd] == commit_rob_pos. A newer rename keeps its tag (stale commit).
- Issue (posedge, rdy=1, issue_to_reg_enable=1, issue_to_reg_rd != 0): tag[rd] <= issue_to_reg_rob_pos.
- Issue and commit to the same rd in the same cycle: the value is written; the issue tag wins over the tag clear.
- clr=1 at posedge (rdy=1):
  - All tags are cleared to 0.
  - A commit write in the same cycle is still applied to val; this is a JALR that commits and flushes together.
  - Any issue in that cycle is discarded; no tag is set.
- x0: never written, never tagged. Reads of x0 return val 0 and tag 0.
- Read path, combinational, identical per port:
  - If rs == 0: val 0, tag 0.
  - Else if rob_to_reg_enable, rob_to_reg_rd == rs and tag[rs] == commit_rob_pos: bypass. Val = rob_to_reg_val, tag 0.
  - Else: val[rs], tag[rs].
- No bypass from same-cycle issue. The decoder's reads see the mapping from before its own rename, so "add x1,x1,x2" reads x1's prior producer.
- Latency: a write or rename is visible to reads in the cycle after the edge; commit data is visible in the same cycle via the bypass.

Decomposition:
- Shared definition header holds:
  - REG_POS_TYPE [4:0], DATA_TYPE [31:0], ROB_WRAP_POS_TYPE [ROB_POS_WIDTH:0], ROB_POS_TYPE.
  - REG_NUM, TRUE/FALSE.
  - Tag-valid convention: MSB set.
- One natural sub-module, reg_file_read_port. It is the combinational x0/bypass/array mux, instantiated twice for rs1 and rs2.
- The array and the update logic stay in reg_file.

Test Plan:
- Reset, then read x5 and x0 -> val 0x0, tag 0x00 on both ports. Assert rst mid-run with x3 tagged -> tag 0 immediately, without waiting for a clock edge.
- Issue rd=5 tag 0x11, then commit rd=5 pos 0x11 val 0xDEADBEEF. Reads between the two events -> tag 0x11. During the commit cycle, rs1=5 -> val 0xDEADBEEF, tag 0 (bypass). Next cycle: same from the array.
- Issue rd=7 tag 0x12, then rd=7 tag 0x13. Commit rd=7 pos 0x12 val 0x55 -> val[7]=0x55, tag[7] stays 0x13. Commit pos 0x13 val 0x66 -> tag 0, val 0x66.
- Same cycle: issue rd=9 tag 0x14 and commit rd=9 pos 0x10 (matching tag) val 0xAA. Read during that cycle -> val 0xAA, tag 0. Next cycle -> tag 0x14, val 0xAA.
- Tag x1, x2, x31. Pulse clr together with commit rd=4 val 0x1234 and issue rd=6 -> next cycle all tags 0, val[4]=0x1234, x6 untagged.
- Commit rd=0 val 0xFFFFFFFF and issue rd=0 -> x0 reads 0/0. With rdy=0, a commit to rd=8 leaves val[8] unchanged.
